// File: rtl/monox_out_pingpong_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : monox_out_pingpong_seq                                         |
// | Brief   : Ping-pong capture of monox yellow/green write streams with a   |
// |           start/done handshake to the next hyper-block stage.            |
// |           Optional write-count checker: define PP_WRCHECK_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module monox_out_pingpong_seq #(
  parameter int DATA_WIDTH  = 64,
  parameter int INDEX_WIDTH = 13,
  parameter int ADDR_WIDTH  = INDEX_WIDTH - 1,
  parameter int POWER_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [POWER_WIDTH-1:0]  i_n,
  input  logic [4*DATA_WIDTH-1:0] i_data_y,
  input  logic [4*DATA_WIDTH-1:0] i_data_g,
  input  logic [4*ADDR_WIDTH-1:0] i_addr_y,
  input  logic [4*ADDR_WIDTH-1:0] i_addr_g,
  input  logic [3:0]              i_we_y,
  input  logic [3:0]              i_we_g,
  input  logic                    i_done_up,
  output logic                    o_ready_up,
  output logic [4*DATA_WIDTH-1:0] o_data_y,
  output logic [4*DATA_WIDTH-1:0] o_data_g,
  output logic [4*ADDR_WIDTH-1:0] o_addr_y,
  output logic [4*ADDR_WIDTH-1:0] o_addr_g,
  output logic [3:0]              o_we_y0,
  output logic [3:0]              o_we_g0,
  output logic [3:0]              o_we_y1,
  output logic [3:0]              o_we_g1,
  output logic                    o_start_dn,
  output logic                    o_rdsel_dn,
  output logic [POWER_WIDTH-1:0]  o_n_dn,
  input  logic                    i_done_dn,
  output logic                    o_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } bank_state_t;

  bank_state_t            r_state [2];
  logic [POWER_WIDTH-1:0] r_n     [2];
  logic                   r_wb;
  logic                   r_rb;

  logic       w_ready;
  logic [3:0] w_we_y;
  logic [3:0] w_we_g;
  logic       w_wr_any;
  logic       w_close;
  logic       w_start;
  logic       w_free;

  assign w_ready    = (r_state[r_wb] == ST_EMPTY) || (r_state[r_wb] == ST_FILL);
  assign o_ready_up = w_ready;
  assign w_we_y     = i_we_y & {4{w_ready}};
  assign w_we_g     = i_we_g & {4{w_ready}};
  assign w_wr_any   = |{w_we_y, w_we_g};
  assign w_close    = i_done_up & w_ready;
  // Only one bank may be draining, so the read bank is the only DRAIN candidate.
  assign w_start    = (r_state[r_rb] == ST_FULL) &&
                      (r_state[0] != ST_DRAIN) && (r_state[1] != ST_DRAIN);
  assign w_free     = i_done_dn & (r_state[r_rb] == ST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state[0] <= ST_EMPTY;
      r_state[1] <= ST_EMPTY;
      r_n[0]     <= '0;
      r_n[1]     <= '0;
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      o_data_y   <= '0;
      o_data_g   <= '0;
      o_addr_y   <= '0;
      o_addr_g   <= '0;
      o_we_y0    <= '0;
      o_we_g0    <= '0;
      o_we_y1    <= '0;
      o_we_g1    <= '0;
      o_start_dn <= 1'b0;
      o_rdsel_dn <= 1'b0;
      o_n_dn     <= '0;
    end else begin
      o_data_y <= i_data_y;
      o_data_g <= i_data_g;
      o_addr_y <= i_addr_y;
      o_addr_g <= i_addr_g;
      o_we_y0  <= r_wb ? 4'h0 : w_we_y;
      o_we_g0  <= r_wb ? 4'h0 : w_we_g;
      o_we_y1  <= r_wb ? w_we_y : 4'h0;
      o_we_g1  <= r_wb ? w_we_g : 4'h0;

      if (w_wr_any && (r_state[r_wb] == ST_EMPTY)) begin
        r_state[r_wb] <= ST_FILL;
      end
      // Close wins over the EMPTY->FILL step so a write in the closing cycle lands in a FULL bank.
      if (w_close) begin
        r_state[r_wb] <= ST_FULL;
        r_n[r_wb]     <= i_n;
        r_wb          <= ~r_wb;
      end

      o_start_dn <= w_start;
      if (w_start) begin
        r_state[r_rb] <= ST_DRAIN;
        o_rdsel_dn    <= r_rb;
        o_n_dn        <= r_n[r_rb];
      end

      if (w_free) begin
        r_state[r_rb] <= ST_EMPTY;
        r_rb          <= ~r_rb;
      end
    end
  end

`ifdef PP_WRCHECK_EN
  localparam int CNT_W = INDEX_WIDTH + 2;

  function automatic logic [CNT_W-1:0] f_pop4(input logic [3:0] v);
    return CNT_W'(v[0]) + CNT_W'(v[1]) + CNT_W'(v[2]) + CNT_W'(v[3]);
  endfunction

  logic [CNT_W-1:0] r_cnt [2];
  logic [CNT_W-1:0] w_total;
  logic [31:0]      w_target;

  // Lane-writes in the closing cycle belong to the closing bank, so they count toward the check.
  assign w_total  = r_cnt[r_wb] + f_pop4(w_we_y) + f_pop4(w_we_g);
  assign w_target = 32'd1 << (32'(i_n) + 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
      o_err    <= 1'b0;
    end else begin
      if (w_wr_any) begin
        r_cnt[r_wb] <= w_total;
      end
      if (w_free) begin
        r_cnt[r_rb] <= '0;
      end
      if (w_close && (32'(w_total) != w_target)) begin
        o_err <= 1'b1;
      end
      if (!w_ready && (|{i_we_y, i_we_g} || i_done_up)) begin
        o_err <= 1'b1;
      end
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_monox_out_pingpong_seq.sv
`default_nettype none
// Directed scoreboard bench for monox_out_pingpong_seq (default parameters).
module tb_monox_out_pingpong_seq;
  localparam int DW = 64;
  localparam int IW = 13;
  localparam int AW = IW - 1;
  localparam int PW = 4;
`ifdef PP_WRCHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [PW-1:0]   i_n;
  logic [4*DW-1:0] i_data_y, i_data_g, o_data_y, o_data_g;
  logic [4*AW-1:0] i_addr_y, i_addr_g, o_addr_y, o_addr_g;
  logic [3:0]      i_we_y, i_we_g, o_we_y0, o_we_g0, o_we_y1, o_we_g1;
  logic            i_done_up, i_done_dn, o_ready_up, o_start_dn, o_rdsel_dn, o_err;
  logic [PW-1:0]   o_n_dn;

  monox_out_pingpong_seq #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .POWER_WIDTH(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_n(i_n),
    .i_data_y(i_data_y), .i_data_g(i_data_g), .i_addr_y(i_addr_y), .i_addr_g(i_addr_g),
    .i_we_y(i_we_y), .i_we_g(i_we_g), .i_done_up(i_done_up), .o_ready_up(o_ready_up),
    .o_data_y(o_data_y), .o_data_g(o_data_g), .o_addr_y(o_addr_y), .o_addr_g(o_addr_g),
    .o_we_y0(o_we_y0), .o_we_g0(o_we_g0), .o_we_y1(o_we_y1), .o_we_g1(o_we_g1),
    .o_start_dn(o_start_dn), .o_rdsel_dn(o_rdsel_dn), .o_n_dn(o_n_dn),
    .i_done_dn(i_done_dn), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      y0, g0, y1, g1;
    logic [4*DW-1:0] dy, dg;
    logic [4*AW-1:0] ay, ag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one cycle of stimulus from a negedge; bank = 0/1 target bank, -1 = dropped.
  task automatic cyc(input logic [3:0] wy, input logic [3:0] wg, input logic dup,
                     input logic ddn, input int bank, input bit fixed);
    exp_t e;
    exp_t g;
    if (fixed) begin
      i_data_y = 256'hAB;
      i_data_g = '0;
      i_addr_y = 48'd5;
      i_addr_g = '0;
    end else begin
      i_data_y = rnd();
      i_data_g = rnd();
      i_addr_y = 48'(rnd());
      i_addr_g = 48'(rnd());
    end
    i_we_y    = wy;
    i_we_g    = wg;
    i_done_up = dup;
    i_done_dn = ddn;
    e.y0 = (bank == 0) ? wy : 4'h0;
    e.g0 = (bank == 0) ? wg : 4'h0;
    e.y1 = (bank == 1) ? wy : 4'h0;
    e.g1 = (bank == 1) ? wg : 4'h0;
    e.dy = i_data_y;
    e.dg = i_data_g;
    e.ay = i_addr_y;
    e.ag = i_addr_g;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_we_y    = '0;
    i_we_g    = '0;
    i_done_up = 1'b0;
    i_done_dn = 1'b0;
    g = sb.pop_front();
    chk("we_y0",  256'(o_we_y0),  256'(g.y0));
    chk("we_g0",  256'(o_we_g0),  256'(g.g0));
    chk("we_y1",  256'(o_we_y1),  256'(g.y1));
    chk("we_g1",  256'(o_we_g1),  256'(g.g1));
    chk("data_y", 256'(o_data_y), 256'(g.dy));
    chk("data_g", 256'(o_data_g), 256'(g.dg));
    chk("addr_y", 256'(o_addr_y), 256'(g.ay));
    chk("addr_g", 256'(o_addr_g), 256'(g.ag));
  endtask

  task automatic ctl(input string tag, input logic rdy, input logic st,
                     input logic sel, input logic [PW-1:0] n, input logic err);
    chk({tag, ".ready"}, 256'(o_ready_up), 256'(rdy));
    chk({tag, ".start"}, 256'(o_start_dn), 256'(st));
    chk({tag, ".rdsel"}, 256'(o_rdsel_dn), 256'(sel));
    chk({tag, ".n_dn"},  256'(o_n_dn),     256'(n));
    chk({tag, ".err"},   256'(o_err),      256'(err));
  endtask

  initial begin
    rst_n = 1'b0;
    i_n = '0; i_data_y = '0; i_data_g = '0; i_addr_y = '0; i_addr_g = '0;
    i_we_y = '0; i_we_g = '0; i_done_up = 1'b0; i_done_dn = 1'b0;
    repeat (2) @(negedge clk);
    ctl("reset", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("reset.we_y0", 256'(o_we_y0), 256'd0);
    chk("reset.data_y", 256'(o_data_y), 256'd0);
    rst_n = 1'b1;

    // Single yellow lane0 write, then fill bank0 to 16 lane-writes.
    cyc(4'b0001, 4'h0, 1'b0, 1'b0, 0, 1'b1);
    chk("first.addr_lane0", 256'(o_addr_y[AW-1:0]), 256'd5);
    chk("first.data_lane0", 256'(o_data_y[DW-1:0]), 256'hAB);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 0, 1'b0);
    cyc(4'hF, 4'h7, 1'b0, 1'b0, 0, 1'b0);
    i_n = 4'd3;
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0);
    ctl("close0", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 1, 1'b0);
    ctl("start0", 1'b1, 1'b1, 1'b0, 4'd3, 1'b0);

    // Close bank1 with n=2 while bank0 drains: both busy, write dropped.
    i_n = 4'd2;
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1, 1'b0);
    ctl("close1", 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    cyc(4'hF, 4'h0, 1'b0, 1'b0, -1, 1'b0);
    ctl("drop", 1'b0, 1'b0, 1'b0, 4'd3, CHK);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    ctl("free0", 1'b1, 1'b0, 1'b0, 4'd3, CHK);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    ctl("start1", 1'b1, 1'b1, 1'b1, 4'd2, CHK);

    // Close bank0 (with a same-cycle write) while freeing bank1.
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 0, 1'b0);
    ctl("simul", 1'b1, 1'b0, 1'b1, 4'd2, CHK);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 1, 1'b0);
    ctl("simul_start", 1'b1, 1'b1, 1'b0, 4'd2, CHK);

    // Asynchronous reset while bank0 drains.
    #2 rst_n = 1'b0;
    #1;
    ctl("midrst", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("midrst.we_y1", 256'(o_we_y1), 256'd0);
    chk("midrst.data_y", 256'(o_data_y), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh fill on bank0 with only 15 lane-writes for n=3.
    cyc(4'b0001, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0, 1'b0, 0, 1'b0);
    cyc(4'hF, 4'h3, 1'b0, 1'b0, 0, 1'b0);
    ctl("short_pre", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    i_n = 4'd3;
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0);
    ctl("short_close", 1'b1, 1'b0, 1'b0, 4'd0, CHK);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, 1, 1'b0);
    ctl("short_start", 1'b1, 1'b1, 1'b0, 4'd3, CHK);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, 1, 1'b0);
    ctl("short_hold", 1'b1, 1'b0, 1'b0, 4'd3, CHK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
